flag_stream_deserializer: RTL

//   Receive-side counterpart of the nibble-to-flag path: collects a 1-bit flag

---
 rtl/flag_stream_deserializer.sv | 99 +++++++++
 1 files changed

// File: rtl/flag_stream_deserializer.sv
// Collects an LSB-first serial flag stream into W-bit words behind a one-word valid/ready buffer.
// Optional even-parity bit per word when FLAG_DESER_PARITY_EN is defined.
module flag_stream_deserializer #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic {COLLECT, PARITY} state_t;

  state_t        state;
  logic [W-1:0]  sr;
  logic [CW-1:0] count;
  logic [W-1:0]  next_sr;
  logic [W-1:0]  word;
  logic          complete;
  logic          perr;
  logic          handshake;

  assign handshake = out_valid && out_ready;

  always_comb begin
    next_sr = sr;
    for (int unsigned i = 0; i < W; i++) begin
      if (count == CW'(i)) next_sr[i] = in_bit;
    end
    word     = next_sr;
    complete = 1'b0;
    perr     = 1'b0;
`ifdef FLAG_DESER_PARITY_EN
    // In PARITY the shift register already holds all data bits; the incoming bit is parity only.
    if (in_valid && state == PARITY) begin
      complete = 1'b1;
      word     = sr;
      perr     = (^sr) ^ in_bit;
    end
`else
    if (in_valid && state == COLLECT && count == LAST) complete = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr         <= '0;
      count      <= '0;
      state      <= COLLECT;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_count  <= '0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      overrun <= 1'b0;

      if (in_valid) begin
        if (complete) begin
          sr    <= '0;
          count <= '0;
          state <= COLLECT;
        end else begin
          sr    <= next_sr;
          count <= count + CW'(1);
`ifdef FLAG_DESER_PARITY_EN
          if (count == LAST) state <= PARITY;
`endif
        end
      end

      if (handshake) out_count <= out_count + CNT_W'(1);

      // A completed word may refill the buffer in the same cycle it is drained.
      if (complete) begin
        if (!out_valid || out_ready) begin
          out_data   <= word;
          out_valid  <= 1'b1;
          parity_err <= perr;
        end else begin
          overrun <= 1'b1;
        end
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
